// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-Lite arbiter and master-side mux for the 3DES subsystem.
// Address-phase and data-phase ownership are tracked separately.
module ahb_bus_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int PARK_MASTER = 0,
  parameter int MAX_TENURE  = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HREADY,
  input  logic        HBUSREQ_M0,
  input  logic        HBUSREQ_M1,
  input  logic        HLOCK_M0,
  input  logic        HLOCK_M1,
  input  logic [1:0]  HTRANS_M0,
  input  logic [1:0]  HTRANS_M1,
  input  logic [31:0] HADDR_M0,
  input  logic [31:0] HADDR_M1,
  input  logic        HWRITE_M0,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M0,
  input  logic [2:0]  HSIZE_M1,
  input  logic [2:0]  HBURST_M0,
  input  logic [2:0]  HBURST_M1,
  input  logic [3:0]  HPROT_M0,
  input  logic [3:0]  HPROT_M1,
  input  logic [63:0] HWDATA_M0,
  input  logic [63:0] HWDATA_M1,
  output logic        HGRANT_M0,
  output logic        HGRANT_M1,
  output logic        HMASTER,
  output logic        HMASTLOCK,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [63:0] HWDATA
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam logic [1:0] TR_BUSY    = 2'b01;
  localparam logic [1:0] TR_SEQ     = 2'b11;
  localparam logic [2:0] BURST_INCR = 3'b001;
  localparam logic [7:0] TEN_MAX    = 8'(MAX_TENURE);
  localparam owner_e     PARK       = owner_e'(PARK_MASTER != 0);
  localparam logic       RR         = (ROUND_ROBIN != 0);

  owner_e     addr_owner_q, addr_owner_d;
  owner_e     data_owner_q, data_owner_d;
  logic [7:0] tenure_q, tenure_d;

  owner_e     next_owner;
  owner_e     other_owner;
  logic       own_lock;
  logic       own_req;
  logic       oth_req;
  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic       in_burst;
  logic       tenure_left;

  // Address-phase mux follows addr_owner
  always_comb begin
    HTRANS    = HTRANS_M0;
    HADDR     = HADDR_M0;
    HWRITE    = HWRITE_M0;
    HSIZE     = HSIZE_M0;
    HBURST    = HBURST_M0;
    HPROT     = HPROT_M0;
    HMASTLOCK = HLOCK_M0;
    own_req   = HBUSREQ_M0;
    oth_req   = HBUSREQ_M1;
    if (addr_owner_q == OWN_M1) begin
      HTRANS    = HTRANS_M1;
      HADDR     = HADDR_M1;
      HWRITE    = HWRITE_M1;
      HSIZE     = HSIZE_M1;
      HBURST    = HBURST_M1;
      HPROT     = HPROT_M1;
      HMASTLOCK = HLOCK_M1;
      own_req   = HBUSREQ_M1;
      oth_req   = HBUSREQ_M0;
    end
  end

  // Write data follows the data-phase owner, which lags by one beat
  always_comb begin
    HWDATA = HWDATA_M0;
    if (data_owner_q == OWN_M1) begin
      HWDATA = HWDATA_M1;
    end
  end

  assign HGRANT_M0   = (addr_owner_q == OWN_M0);
  assign HGRANT_M1   = (addr_owner_q == OWN_M1);
  assign HMASTER     = addr_owner_q;
  assign other_owner = (addr_owner_q == OWN_M0) ? OWN_M1 : OWN_M0;

  assign own_lock    = HMASTLOCK;
  assign own_trans   = HTRANS;
  assign own_burst   = HBURST;
  assign in_burst    = (own_trans == TR_BUSY) ||
                       (own_trans == TR_SEQ);
  assign tenure_left = (tenure_q < TEN_MAX);

  always_comb begin
    next_owner = PARK;
    if (own_lock) begin
      next_owner = addr_owner_q;
    end else if (in_burst && own_burst != BURST_INCR) begin
      next_owner = addr_owner_q;
    end else if (in_burst && tenure_left) begin
      next_owner = addr_owner_q;
    end else if (RR) begin
      if (oth_req) begin
        next_owner = other_owner;
      end else if (own_req) begin
        next_owner = addr_owner_q;
      end else begin
        next_owner = PARK;
      end
    end else begin
      if (HBUSREQ_M0) begin
        next_owner = OWN_M0;
      end else if (HBUSREQ_M1) begin
        next_owner = OWN_M1;
      end else begin
        next_owner = PARK;
      end
    end
  end

  // Wait states freeze every register, including ERROR first cycle
  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    tenure_d     = tenure_q;
    if (HREADY) begin
      data_owner_d = addr_owner_q;
      addr_owner_d = next_owner;
      if (next_owner != addr_owner_q) begin
        tenure_d = 8'd0;
      end else if (own_trans[1] && tenure_left) begin
        tenure_d = tenure_q + 8'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_owner_q <= PARK;
      data_owner_q <= PARK;
      tenure_q     <= 8'd0;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      tenure_q     <= tenure_d;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter: RR/PARK0/MAX16 (0),
// fixed priority (1) and MAX_TENURE=4 (2) instances on shared inputs.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [1:0] SEQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000;
  localparam logic [2:0] INC = 3'b001;
  localparam logic [2:0] IN4 = 3'b011;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_0040;
  localparam logic [63:0] D0 = 64'h0000_0000_0000_00A0;
  localparam logic [63:0] D1 = 64'hABCDEF1234567890;
  localparam logic [2:0]  S0 = 3'b010;
  localparam logic [2:0]  S1 = 3'b011;
  localparam logic [3:0]  P0 = 4'b0011;
  localparam logic [3:0]  P1 = 4'b1010;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        r0, r1, l0, l1;
  logic [1:0]  t0, t1;
  logic [2:0]  b0, b1;

  logic        g0 [3];
  logic        g1 [3];
  logic        hm [3];
  logic        ml [3];
  logic [1:0]  ht [3];
  logic [31:0] ha [3];
  logic        hw [3];
  logic [2:0]  hs [3];
  logic [2:0]  hb [3];
  logic [3:0]  hp [3];
  logic [63:0] wd [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    ahb_bus_arbiter #(
      .ROUND_ROBIN((i == 1) ? 0 : 1),
      .PARK_MASTER(0),
      .MAX_TENURE((i == 2) ? 4 : 16)
    ) u_dut (
      .HCLK(clk), .HRESET(rst), .HREADY(rdy),
      .HBUSREQ_M0(r0), .HBUSREQ_M1(r1),
      .HLOCK_M0(l0), .HLOCK_M1(l1),
      .HTRANS_M0(t0), .HTRANS_M1(t1),
      .HADDR_M0(A0), .HADDR_M1(A1),
      .HWRITE_M0(1'b0), .HWRITE_M1(1'b1),
      .HSIZE_M0(S0), .HSIZE_M1(S1),
      .HBURST_M0(b0), .HBURST_M1(b1),
      .HPROT_M0(P0), .HPROT_M1(P1),
      .HWDATA_M0(D0), .HWDATA_M1(D1),
      .HGRANT_M0(g0[i]), .HGRANT_M1(g1[i]),
      .HMASTER(hm[i]), .HMASTLOCK(ml[i]),
      .HTRANS(ht[i]), .HADDR(ha[i]),
      .HWRITE(hw[i]), .HSIZE(hs[i]),
      .HBURST(hb[i]), .HPROT(hp[i]),
      .HWDATA(wd[i])
    );
  end

  typedef struct {
    logic       rst, rdy, r0, r1, l0, l1;
    logic [1:0] t0, t1;
    logic [2:0] b0, b1;
    logic       em;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rst_i, logic rdy_i, logic r0_i, logic r1_i,
    logic [1:0] t0_i, logic [2:0] b0_i,
    logic [1:0] t1_i, logic [2:0] b1_i,
    logic em_i, logic ed_i);
    vec_t v;
    v.rst = rst_i; v.rdy = rdy_i;
    v.r0 = r0_i; v.r1 = r1_i;
    v.l0 = 1'b0; v.l1 = 1'b0;
    v.t0 = t0_i; v.b0 = b0_i;
    v.t1 = t1_i; v.b1 = b1_i;
    v.em = em_i; v.ed = ed_i;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; rdy = v.rdy;
    r0 = v.r0; r1 = v.r1;
    l0 = v.l0; l1 = v.l1;
    t0 = v.t0; t1 = v.t1;
    b0 = v.b0; b1 = v.b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(vec_t v, int n);
    string s;
    s = $sformatf("v%0d", n);
    chk({s, " master"}, 64'(hm[0]), 64'(v.em));
    chk({s, " grant"}, 64'({g1[0], g0[0]}),
        v.em ? 64'd2 : 64'd1);
    chk({s, " haddr"}, 64'(ha[0]), 64'(v.em ? A1 : A0));
    chk({s, " htrans"}, 64'(ht[0]), 64'(v.em ? v.t1 : v.t0));
    chk({s, " ctl"},
        64'({hw[0], hs[0], hb[0], hp[0], ml[0]}),
        v.em ? 64'({1'b1, S1, v.b1, P1, v.l1})
             : 64'({1'b0, S0, v.b0, P0, v.l0}));
    chk({s, " hwdata"}, wd[0], v.ed ? D1 : D0);
  endtask

  vec_t v;

  initial begin
    // reset and parking
    vecs.push_back(mk(1, 1, 0, 0, IDL, SGL, IDL, SGL, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, IDL, SGL, IDL, SGL, 0, 0));
    // M1 single write then park back on M0
    vecs.push_back(mk(0, 1, 0, 1, IDL, SGL, IDL, SGL, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, IDL, SGL, NSQ, SGL, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, IDL, SGL, IDL, SGL, 0, 0));
    // contention alternates
    vecs.push_back(mk(0, 1, 1, 1, NSQ, SGL, NSQ, SGL, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, NSQ, SGL, NSQ, SGL, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, NSQ, SGL, NSQ, SGL, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, NSQ, SGL, NSQ, SGL, 0, 1));
    // M0 INCR4 with wait states, M1 requesting after beat 1
    vecs.push_back(mk(0, 1, 1, 0, NSQ, IN4, IDL, SGL, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, SEQ, IN4, IDL, SGL, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, SEQ, IN4, IDL, SGL, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, SEQ, IN4, IDL, SGL, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, SEQ, IN4, IDL, SGL, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, SEQ, IN4, IDL, SGL, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, IDL, SGL, IDL, SGL, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, IDL, SGL, IDL, SGL, 1, 0));
    // data owner frozen by wait state across handover
    vecs.push_back(mk(0, 0, 0, 0, IDL, SGL, NSQ, SGL, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, IDL, SGL, NSQ, SGL, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, IDL, SGL, IDL, SGL, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      check_main(vecs[i], i);
    end

    // fixed priority: M0 keeps the bus under contention
    drive(mk(1, 1, 0, 0, IDL, SGL, IDL, SGL, 0, 0));
    for (int i = 0; i < 4; i++) begin
      drive(mk(0, 1, 1, 1, NSQ, SGL, NSQ, SGL, 0, 0));
      chk($sformatf("fp%0d master", i), 64'(hm[1]), 64'd0);
    end
    drive(mk(0, 1, 0, 1, IDL, SGL, IDL, SGL, 0, 0));
    chk("fp m1 alone", 64'(hm[1]), 64'd1);

    // undefined INCR capped by MAX_TENURE=4
    drive(mk(1, 1, 0, 0, IDL, SGL, IDL, SGL, 0, 0));
    drive(mk(0, 1, 1, 0, NSQ, INC, IDL, SGL, 0, 0));
    chk("ten beat1", 64'(hm[2]), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      drive(mk(0, 1, 1, 1, SEQ, INC, IDL, SGL, 0, 0));
      chk($sformatf("ten beat%0d", i), 64'(hm[2]), 64'd0);
    end
    drive(mk(0, 1, 1, 1, SEQ, INC, IDL, SGL, 0, 0));
    chk("ten handover", 64'(hm[2]), 64'd1);
    chk("ten wdata", wd[2], D0);

    // locked INCR never broken
    drive(mk(1, 1, 0, 0, IDL, SGL, IDL, SGL, 0, 0));
    v = mk(0, 1, 1, 1, NSQ, INC, IDL, SGL, 0, 0);
    v.l0 = 1'b1;
    drive(v);
    chk("lock beat1", 64'(hm[2]), 64'd0);
    v.t0 = SEQ;
    for (int i = 2; i <= 8; i++) begin
      drive(v);
      chk($sformatf("lock beat%0d", i), 64'(hm[2]), 64'd0);
    end
    chk("lock mastlock", 64'(ml[2]), 64'd1);

    // reset in the middle of an M1 burst
    drive(mk(1, 1, 0, 0, IDL, SGL, IDL, SGL, 0, 0));
    drive(mk(0, 1, 0, 1, IDL, SGL, IDL, SGL, 1, 0));
    chk("mid m1 grant", 64'(hm[0]), 64'd1);
    drive(mk(0, 1, 0, 1, IDL, SGL, NSQ, INC, 1, 1));
    chk("mid tenure", 64'(g_dut[0].u_dut.tenure_q), 64'd1);
    chk("mid wdata m1", wd[0], D1);
    drive(mk(1, 1, 0, 1, IDL, SGL, SEQ, INC, 0, 0));
    chk("rst grant", 64'({g1[0], g0[0]}), 64'd1);
    chk("rst wdata", wd[0], D0);
    chk("rst tenure", 64'(g_dut[0].u_dut.tenure_q), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Two-master AHB-Lite arbiter and master-side multiplexer for the Triple DES subsystem.
- It shares the single AHB-Lite bus between a host CPU port (M0) and a DMA port (M1).
- The address phase and write data of the owning master are routed to the decoder, the DES slave and the default slave.
- It tracks address-phase and data-phase ownership separately, so a grant handover never corrupts an in-flight data phase.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate on contention; 0 = fixed priority, M0 wins.
- PARK_MASTER, 0: master granted when nobody requests (0 or 1).
- MAX_TENURE, 16: max accepted beats of an undefined-length INCR burst before forced re-arbitration (range 1..255).

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  synchronous, active-high reset
- HREADY  in  1  bus ready, from the slave response mux
- HBUSREQ_M0, HBUSREQ_M1  in  1 each  bus request
- HLOCK_M0, HLOCK_M1  in  1 each  locked-sequence request
- HTRANS_M0, HTRANS_M1  in  2 each  transfer type
- HADDR_M0, HADDR_M1  in  32 each  address
- HWRITE_M0, HWRITE_M1  in  1 each  write enable
- HSIZE_M0, HSIZE_M1  in  3 each  transfer size
- HBURST_M0, HBURST_M1  in  3 each  burst type
- HPROT_M0, HPROT_M1  in  4 each  protection
- HWDATA_M0, HWDATA_M1  in  64 each  write data
- HGRANT_M0, HGRANT_M1  out  1 each  address-phase ownership, one-hot
- HMASTER  out  1  current address-phase owner
- HMASTLOCK  out  1  owner's HLOCK, passed through
- HTRANS, HADDR, HWRITE, HSIZE, HBURST, HPROT  out  2/32/1/3/3/4  muxed address phase
- HWDATA  out  64  muxed write data

Behaviour:
- State registers:
  - addr_owner (1 b), drives HMASTER and the one-hot HGRANT.
  - data_owner (1 b).
  - tenure counter, 8 b, saturating at MAX_TENURE.
- Reset (HRESET=1 at posedge) sets addr_owner=data_owner=PARK_MASTER, tenure=0.
  - Resulting outputs: HGRANT one-hot on PARK_MASTER, HMASTER=PARK_MASTER.
  - HTRANS/HADDR etc. come from the parked master through the mux. Mux outputs are combinational.
- Reset mid-burst aborts ownership immediately. No transfer is replayed.
- Address mux: all address-phase outputs and HMASTLOCK select master addr_owner.
- Data mux: HWDATA selects master data_owner.
- All updates occur only at a posedge with HREADY=1. With HREADY=0, every register holds, including during the first cycle of a two-cycle ERROR response.
- On HREADY=1:
  - data_owner <= addr_owner.
  - addr_owner <= next_owner.
- Tenure counter (HREADY=1):
  - Reset to 0 when next_owner != addr_owner.
  - Otherwise increment, saturating, when the owner's HTRANS is NONSEQ(10) or SEQ(11).
- next_owner is the first matching rule:
  1. Owner's HLOCK=1 -> keep owner (locked sequence is never broken).
  2. Owner's HTRANS is BUSY(01) or SEQ(11) and HBURST != INCR(001) -> keep (fixed-length bursts always complete).
  3. Owner's HTRANS is BUSY or SEQ, HBURST=INCR and tenure < MAX_TENURE -> keep.
  4. ROUND_ROBIN=1:
     - Other master requesting -> other.
     - Else owner requesting -> owner.
     - Else PARK_MASTER.
  5. ROUND_ROBIN=0: HBUSREQ_M0 -> 0; else HBUSREQ_M1 -> 1; else PARK_MASTER.
- Simultaneous requests under RR alternate every tenure boundary.
- The parked master issuing IDLE(00) is legal and consumes no tenure.
- Handover cycle: the new owner sees its grant in the cycle after the edge. The old owner's last data phase completes using data_owner, so its HWDATA is still routed.
- Master contract: a master drives address only when granted. The arbiter never forces HTRANS to IDLE.

Test Plan:
1. Reset, RR=1, PARK=0, no requests -> HGRANT_M0=1, HGRANT_M1=0, HMASTER=0; HTRANS mirrors HTRANS_M0=IDLE.
2. M1 requests, single NONSEQ write, HADDR_M1=32'h0000_0040, HWDATA_M1=64'hABCDEF1234567890 -> grant switches next edge; HADDR=32'h40; one edge later HWDATA=64'hABCDEF1234567890 while HMASTER already back to 0.
3. Both request, RR=1, single transfers -> ownership sequence 0,1,0,1 on successive HREADY edges; with RR=0 it stays 0 throughout.
4. M0 INCR4 burst (NONSEQ, SEQ x3), M1 requesting, HREADY low 2 cycles mid-burst -> no handover until the 4th beat is accepted; grants frozen while HREADY=0.
5. M0 INCR undefined length, MAX_TENURE=4, M1 requesting -> grant moves to M1 after the 4th accepted beat. With HLOCK_M0=1 instead, M0 keeps the grant for all beats.
6. Reset asserted during an M1 SEQ beat -> next cycle HGRANT_M0=1, data_owner=0, tenure=0.
